// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and constants for the memory access unit.
//   - state_e     : access sequencer states (TOUT only with MEM_TIMEOUT_EN)
//   - F3_*        : Funct3 access size/sign encodings
//   - TIMEOUT_LIMIT : REQ cycles without ack before an access is abandoned
//   - helpers     : access legality, store byte enables, store lane replication
// Optional feature macro: MEM_TIMEOUT_EN.
package mem_access_pkg;

`ifdef MEM_TIMEOUT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_TOUT = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
`endif

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

  // Legal encoding and natural alignment; unsigned variants exist only for loads.
  function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] lo,
                                     input logic is_store);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~lo[0];
      F3_W:    ok = (lo == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte lanes written by a store of the given size at the given offset.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << lo;
      F3_H:    be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated so every lane carries the low-order item.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      F3_B:    w = {4{d[7:0]}};
      F3_H:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// load_ext: selects the addressed byte/halfword lane of a bus read word and
// sign- or zero-extends it according to Funct3.
//   rdata  : raw 32-bit word from the bus
//   lane   : address bits [1:0] of the load
//   funct3 : load size/sign encoding
//   data   : extended load result
module load_ext
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword out of the word.
  always_comb begin
    byte_s = rdata[7:0];
    half_s = lane[1] ? rdata[31:16] : rdata[15:0];
    case (lane)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
  end

  // Extend the selected item to 32 bits.
  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{byte_s[7]}}, byte_s};
      F3_H:    data = {{16{half_s[15]}}, half_s};
      F3_BU:   data = {24'd0, byte_s};
      F3_HU:   data = {16'd0, half_s};
      F3_W:    data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage access sequencer between the pipeline and a
// simple req/ack bus. One access at a time: IDLE -> REQ (until ack) -> DONE.
// Ports:
//   clk, reset (async, active-low)
//   MemRead, MemWrite, Funct3, Addr, WrData : access request from the decoder
//   RdData   : extended load result, held until the next load completes or a fault
//   Stall    : combinational pipeline freeze
//   MemFault : one-cycle pulse on misaligned/unsupported access (or timeout)
//   bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_ack, bus_rdata : bus side
// Optional feature macro: MEM_TIMEOUT_EN -- abandon an access after
// TIMEOUT_LIMIT REQ cycles without ack through a one-cycle TOUT state.
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        Stall,
  output logic        MemFault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_e      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        mem_fault_q, mem_fault_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
`ifdef MEM_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`endif

  logic        access_s;
  logic        is_store_s;
  logic        ok_s;
  logic [31:0] ext_data_s;

  // Both strobes together are a store.
  assign access_s   = MemRead | MemWrite;
  assign is_store_s = MemWrite;
  assign ok_s       = access_ok(Funct3, Addr[1:0], is_store_s);

  load_ext u_load_ext (
    .rdata  (bus_rdata),
    .lane   (lane_q),
    .funct3 (f3_q),
    .data   (ext_data_s)
  );

  // Freeze while a legal access is being accepted or is on the bus.
  assign Stall = (state_q == ST_REQ) ||
                 ((state_q == ST_IDLE) && access_s && ok_s);

  // Next-state and next-output logic of the access sequencer.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    rd_data_d   = rd_data_q;
    mem_fault_d = 1'b0;
    f3_d        = f3_q;
    lane_d      = lane_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (access_s && ok_s) begin
          state_d     = ST_REQ;
          bus_req_d   = 1'b1;
          bus_we_d    = is_store_s;
          bus_addr_d  = {Addr[31:2], 2'b00};
          bus_wdata_d = store_lanes(Funct3, WrData);
          // Loads fetch the whole word; the lane is picked on return.
          bus_be_d    = is_store_s ? store_be(Funct3, Addr[1:0]) : 4'b1111;
          f3_d        = Funct3;
          lane_d      = Addr[1:0];
`ifdef MEM_TIMEOUT_EN
          cnt_d       = 8'd0;
`endif
        end else if (access_s) begin
          // Illegal access: no bus cycle, just report it.
          mem_fault_d = 1'b1;
          rd_data_d   = 32'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus_ack) begin
          state_d   = ST_DONE;
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            rd_data_d = ext_data_s;
          end else begin
            rd_data_d = rd_data_q;
          end
        end else begin
`ifdef MEM_TIMEOUT_EN
          // cnt_q counts completed wait cycles; this one is the last allowed.
          if (cnt_q == (TIMEOUT_LIMIT - 8'd1)) begin
            state_d     = ST_TOUT;
            bus_req_d   = 1'b0;
            mem_fault_d = 1'b1;
            rd_data_d   = 32'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`else
          state_d = ST_REQ;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
`ifdef MEM_TIMEOUT_EN
      ST_TOUT: begin
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_be_q    <= 4'd0;
      rd_data_q   <= 32'd0;
      mem_fault_q <= 1'b0;
      f3_q        <= 3'd0;
      lane_q      <= 2'd0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      rd_data_q   <= rd_data_d;
      mem_fault_q <= mem_fault_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;
  assign RdData    = rd_data_q;
  assign MemFault  = mem_fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// accesses, all compared against a transaction-level model every cycle.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr, WrData;
  logic [31:0] RdData;
  logic        Stall, MemFault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .Addr(Addr), .WrData(WrData), .RdData(RdData),
    .Stall(Stall), .MemFault(MemFault), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  int n_total = 0;
  int n_pass  = 0;

  // expected per-cycle values, set by the driver from the model
  logic        chk_en = 1'b0;
  logic        e_stall = 1'b0, e_req = 1'b0, e_fault = 1'b0, e_we = 1'b0, e_chk_be = 1'b0;
  logic [31:0] e_addr = 32'd0, e_wdata = 32'd0;
  logic [3:0]  e_be = 4'd0;
  logic [31:0] m_rd = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic model_ok(input logic [2:0] f3, input logic [1:0] lo, input logic st);
    int sz;
    if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) sz = int'(f3);
    else if (!st && (f3 == 3'd4 || f3 == 3'd5)) sz = int'(f3) - 4;
    else return 1'b0;
    return (int'(lo) % (1 << sz)) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [1:0] lo,
                                             input logic [2:0] f3);
    logic [31:0] v;
    v = rdata >> (8 * int'(lo));
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3'd4: v = v & 32'hFF;
      3'd5: v = v & 32'hFFFF;
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] one, three;
    one = 4'd1; three = 4'd3;
    if (f3 == 3'd0) return one << lo;
    if (f3 == 3'd1) return three << lo;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h01010101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("Stall", 32'(Stall), 32'(e_stall));
      chk("bus_req", 32'(bus_req), 32'(e_req));
      chk("MemFault", 32'(MemFault), 32'(e_fault));
      chk("RdData", RdData, m_rd);
      if (e_req) begin
        chk("bus_we", 32'(bus_we), 32'(e_we));
        chk("bus_addr", bus_addr, e_addr);
        if (e_we) chk("bus_wdata", bus_wdata, e_wdata);
        if (e_chk_be) chk("bus_be", 32'(bus_be), 32'(e_be));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'd0; Addr = 32'd0; WrData = 32'd0;
    bus_ack = 1'b0;
    e_stall = 1'b0; e_req = 1'b0; e_fault = 1'b0;
  endtask

  task automatic idle_cycle();
    set_idle();
    next_cycle();
  endtask

  // One access starting in IDLE; returns at the next IDLE cycle (posedge+1).
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int wait_n, input logic [31:0] rdata);
    logic ok;
    ok = model_ok(f3, addr[1:0], wr);
    MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = addr; WrData = wd;
    bus_ack = 1'b0; bus_rdata = $urandom;
    e_req = 1'b0; e_fault = 1'b0; e_stall = ok;
    next_cycle();
    if (!ok) begin
      set_idle();
      e_fault = 1'b1; m_rd = 32'd0;
      next_cycle();
      set_idle();
      return;
    end
    e_req = 1'b1; e_stall = 1'b1; e_we = wr;
    e_addr = {addr[31:2], 2'b00};
    e_wdata = model_wdata(f3, wd);
    e_be = wr ? model_be(f3, addr[1:0]) : 4'hF;
    e_chk_be = wr || (f3 == 3'd2);
    for (int i = 0; i < wait_n; i++) begin
      bus_ack = 1'b0; bus_rdata = $urandom;
      next_cycle();
    end
    bus_ack = 1'b1; bus_rdata = rdata;
    next_cycle();
    // DONE: inputs must be ignored
    bus_ack = 1'b0; bus_rdata = $urandom;
    e_req = 1'b0; e_stall = 1'b0;
    if (!wr) m_rd = model_load(rdata, addr[1:0], f3);
    MemRead = 1'($urandom); MemWrite = 1'($urandom); Funct3 = 3'($urandom); Addr = $urandom;
    next_cycle();
    set_idle();
  endtask

  logic [2:0] f3_tab [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};

  initial begin
    reset = 1'b0;
    set_idle();
    bus_rdata = 32'd0;
    #12;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_RdData", RdData, 32'd0);
    chk("rst_MemFault", 32'(MemFault), 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_Stall", 32'(Stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    chk_en = 1'b1;
    idle_cycle();

    // pin the model against hand-computed values
    chk("pin_lb", model_load(32'h80112233, 2'd3, 3'd0), 32'hFFFFFF80);
    chk("pin_lbu", model_load(32'h80112233, 2'd3, 3'd4), 32'h00000080);
    chk("pin_lh", model_load(32'h8001F234, 2'd0, 3'd1), 32'hFFFFF234);
    chk("pin_sh_wdata", model_wdata(3'd1, 32'h0000ABCD), 32'hABCDABCD);
    chk("pin_sh_be", 32'(model_be(3'd1, 2'd2)), 32'h0000000C);
    chk("pin_lw_mis", 32'(model_ok(3'd2, 2'd1, 1'b0)), 32'd0);

    // LW 0x100, ack on second REQ cycle
    do_access(1'b1, 1'b0, 3'd2, 32'h100, 32'd0, 1, 32'hDEADBEEF);
    chk("lw_rd", RdData, 32'hDEADBEEF);
    do_access(1'b1, 1'b0, 3'd0, 32'h103, 32'd0, 0, 32'h80112233);
    chk("lb_rd", RdData, 32'hFFFFFF80);
    do_access(1'b1, 1'b0, 3'd4, 32'h103, 32'd0, 2, 32'h80112233);
    chk("lbu_rd", RdData, 32'h00000080);
    // SH 0x202; RdData must survive the store
    do_access(1'b0, 1'b1, 3'd1, 32'h202, 32'h0000ABCD, 0, 32'd0);
    chk("sh_keeps_rd", RdData, 32'h00000080);
    // both strobes = store (SB)
    do_access(1'b1, 1'b1, 3'd0, 32'h301, 32'h000000A5, 1, 32'h11111111);
    chk("rdwr_store_keeps_rd", RdData, 32'h00000080);
    // misaligned LW
    do_access(1'b1, 1'b0, 3'd2, 32'h101, 32'd0, 0, 32'd0);
    chk("mis_rd", RdData, 32'd0);

    // random traffic
    for (int t = 0; t < 80; t++) begin
      int kind;
      kind = $urandom_range(0, 2);
      do_access(kind != 1, kind != 0, f3_tab[$urandom_range(0, 9)], $urandom, $urandom,
                $urandom_range(0, 4), $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    // reset in REQ before ack
    do_access(1'b1, 1'b0, 3'd2, 32'h500, 32'd0, 0, 32'h12345678);
    chk_en = 1'b0;
    MemRead = 1'b1; Funct3 = 3'd2; Addr = 32'h300;
    next_cycle();
    chk("r_req_before", 32'(bus_req), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("r_bus_req", 32'(bus_req), 32'd0);
    chk("r_RdData", RdData, 32'd0);
    chk("r_bus_addr", bus_addr, 32'd0);
    chk("r_bus_be", 32'(bus_be), 32'd0);
    chk("r_Stall", 32'(Stall), 32'd1);
    MemRead = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    m_rd = 32'd0;
    set_idle();
    chk_en = 1'b1;
    do_access(1'b1, 1'b0, 3'd2, 32'h300, 32'd0, 1, 32'hCAFEF00D);
    chk("after_rst_lw", RdData, 32'hCAFEF00D);

    // ack never arrives
    MemRead = 1'b1; Funct3 = 3'd2; Addr = 32'h400; bus_ack = 1'b0;
    e_stall = 1'b1; e_req = 1'b0; e_fault = 1'b0;
    next_cycle();
    e_req = 1'b1; e_we = 1'b0; e_addr = 32'h400; e_be = 4'hF; e_chk_be = 1'b1;
`ifdef MEM_TIMEOUT_EN
    repeat (255) next_cycle();
    set_idle();
    e_fault = 1'b1; m_rd = 32'd0;
    next_cycle();
    chk("tout_rd", RdData, 32'd0);
    set_idle();
    next_cycle();
`else
    repeat (300) next_cycle();
    chk("no_tout_stall", 32'(Stall), 32'd1);
    bus_ack = 1'b1; bus_rdata = 32'h0BADF00D;
    next_cycle();
    set_idle();
    m_rd = 32'h0BADF00D;
    next_cycle();
`endif
    idle_cycle();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL have ports MemRead and MemWrite, input, 1 each, memory-stage control strobes from the decoder.
REQ-004 SHALL have port Funct3, input, 3, access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-005 SHALL have ports Addr and WrData, input, 32 each, effective address and store data.
REQ-006 SHALL have ports RdData, output, 32, extended load result; Stall, output, 1, pipeline freeze; MemFault, output, 1, fault pulse.
REQ-007 SHALL have ports bus_req, bus_we (output, 1), bus_addr (output, 32, word-aligned), bus_wdata (output, 32), bus_be (output, 4), bus_ack (input, 1), bus_rdata (input, 32).

Function
REQ-008 SHALL implement FSM states IDLE, REQ, DONE (plus TOUT under REQ-020).
REQ-009 In IDLE, a valid aligned access SHALL latch address, data, Funct3 and direction, and move to REQ next cycle.
REQ-010 In REQ, bus_req SHALL stay 1 with stable bus_we/addr/wdata/be until the cycle bus_ack=1; that edge SHALL capture bus_rdata and move to DONE.
REQ-011 In DONE, Stall SHALL be 0, RdData SHALL hold the result, MemRead/MemWrite SHALL be ignored, next state IDLE.
REQ-012 Stall SHALL be combinational: 1 in REQ, and 1 in IDLE when (MemRead|MemWrite) and no fault; else 0.
REQ-013 Minimum access latency SHALL be 3 cycles (IDLE, REQ with ack, DONE); each extra ack-wait cycle adds one.
REQ-014 Store byte enables SHALL be: SB 1<<Addr[1:0]; SH 0011 (Addr[1]=0) or 1100; SW 1111; store data replicated across lanes.
REQ-015 Loads SHALL select the lane by Addr[1:0] and sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes through.
REQ-016 Misalignment (half at odd address, word with Addr[1:0]!=0) or unsupported Funct3 SHALL produce no bus cycle, MemFault=1 for one cycle, Stall=0, RdData=0.
REQ-017 MemRead and MemWrite both 1 SHALL be treated as a store.
REQ-018 RdData SHALL hold its last value until the next DONE or fault; stores leave it unchanged.

Reset
REQ-019 Reset assertion SHALL immediately force state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, RdData=0, MemFault=0, abandoning any in-flight access; Stall then follows REQ-012.

Configuration
REQ-020 With MEM_TIMEOUT_EN defined, an 8-bit counter SHALL run in REQ; at 255 cycles without ack the access SHALL abort via TOUT (one cycle, bus_req=0, MemFault=1, RdData=0) then IDLE; without the macro REQ waits indefinitely and no counter exists.

Structure
REQ-021 Package mem_access_pkg SHALL hold the state enum, Funct3 size/sign constants and the timeout limit (255).
REQ-022 Lane selection and sign/zero extension SHALL be a sub-module load_ext.

Verification
REQ-023 LW Addr=0x100, ack 2nd REQ cycle, bus_rdata=0xDEADBEEF -> bus_addr=0x100, be=1111, Stall 1 for 3 cycles, RdData=0xDEADBEEF in DONE.
REQ-024 LB Addr=0x103, bus_rdata=0x80112233 -> RdData=0xFFFFFF80; LBU same -> 0x00000080.
REQ-025 SH Addr=0x202, WrData=0x0000ABCD -> bus_we=1, be=1100, bus_wdata=0xABCDABCD, bus_addr=0x200.
REQ-026 LW Addr=0x101 -> no bus_req, MemFault pulse 1 cycle, Stall=0, RdData=0.
REQ-027 Reset pulled low in REQ before ack -> bus_req 0 same cycle, IDLE, RdData=0; next LW completes normally.
REQ-028 MEM_TIMEOUT_EN, ack never asserted -> MemFault after 255 REQ cycles, Stall drops, RdData=0; without macro Stall remains 1.
